// File: rtl/mul_share_arb.sv
// mul_share_arb
// Round-robin arbiter and sequencer that shares one W x W unsigned multiplier
// among NREQ requesters. It runs one multiply at a time. A watchdog bounds the
// wait for the multiplier, and the 2W-bit product is routed back to the
// requester that was granted.
//
// Ports
//   clk, rst_n      : single rising-edge clock, asynchronous active-low reset
//   req             : per-requester request level
//   req_mcand       : packed multiplicands, requester i at [i*W +: W]
//   req_mlier       : packed multipliers, same packing
//   gnt             : one-hot pulse, the operands of that requester were captured
//   resp_done       : one-hot pulse, the result for that requester is on resp_prodt
//   resp_prodt      : product, valid only while a resp_done bit is high
//   resp_err        : high with resp_done when the multiplier timed out
//   busy            : high whenever the sequencer is not idle
//   mul_start       : one-cycle start pulse to the shared multiplier
//   mul_mcand/mlier : multiplier operands, held from ISSUE through WAIT
//   mul_done        : multiplier completion pulse (honoured only in WAIT)
//   mul_prodt       : multiplier product, sampled with mul_done
//
// All outputs come straight from registers. No combinational path runs from
// req or mul_done to any output.

module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_mcand,
    input  logic [NREQ*W-1:0]   req_mlier,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     resp_done,
    output logic [2*W-1:0]      resp_prodt,
    output logic                resp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [W-1:0]        mul_mcand,
    output logic [W-1:0]        mul_mlier,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_prodt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      sel_r;
    logic [CW-1:0]      cnt_r;
    logic [NREQ-1:0]    gnt_r;
    logic [NREQ-1:0]    resp_done_r;
    logic [2*W-1:0]     resp_prodt_r;
    logic               resp_err_r;
    logic               busy_r;
    logic               mul_start_r;
    logic [W-1:0]       mcand_r;
    logic [W-1:0]       mlier_r;

    logic               win_found_s;
    logic [IW-1:0]      win_idx_s;
    logic [IW-1:0]      cand_s;
    logic [IW-1:0]      next_ptr_s;
    logic [W-1:0]       win_mcand_s;
    logic [W-1:0]       win_mlier_s;
    logic               timeout_s;

    // One-hot decode of a requester index
    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = {NREQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin search: the first requesting index starting at ptr_r, wrapping
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand_s      = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IW'((int'(ptr_r) + k) % NREQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer after a grant, plus the operand mux and watchdog compare
    always_comb begin
        if (win_idx_s == IW'(NREQ - 1)) begin
            next_ptr_s = {IW{1'b0}};
        end else begin
            next_ptr_s = win_idx_s + IW'(1);
        end
        win_mcand_s = req_mcand[win_idx_s*W +: W];
        win_mlier_s = req_mlier[win_idx_s*W +: W];
        timeout_s   = (cnt_r == CW'(TIMEOUT - 1));
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {IW{1'b0}};
            sel_r        <= {IW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            gnt_r        <= {NREQ{1'b0}};
            resp_done_r  <= {NREQ{1'b0}};
            resp_prodt_r <= {(2*W){1'b0}};
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            mul_start_r  <= 1'b0;
            mcand_r      <= {W{1'b0}};
            mlier_r      <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_done_r  <= {NREQ{1'b0}};
                    resp_prodt_r <= {(2*W){1'b0}};
                    resp_err_r   <= 1'b0;
                    if (win_found_s) begin
                        sel_r       <= win_idx_s;
                        ptr_r       <= next_ptr_s;
                        mcand_r     <= win_mcand_s;
                        mlier_r     <= win_mlier_s;
                        gnt_r       <= onehot(win_idx_s);
                        mul_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        gnt_r       <= {NREQ{1'b0}};
                        mul_start_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    gnt_r       <= {NREQ{1'b0}};
                    mul_start_r <= 1'b0;
                    cnt_r       <= {CW{1'b0}};
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the last watchdog cycle still wins
                    if (mul_done) begin
                        resp_prodt_r <= mul_prodt;
                        resp_err_r   <= 1'b0;
                        resp_done_r  <= onehot(sel_r);
                        state_r      <= ST_RESP;
                    end else if (timeout_s) begin
                        resp_prodt_r <= {(2*W){1'b0}};
                        resp_err_r   <= 1'b1;
                        resp_done_r  <= onehot(sel_r);
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r        <= cnt_r + CW'(1);
                        state_r      <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    resp_done_r  <= {NREQ{1'b0}};
                    resp_prodt_r <= {(2*W){1'b0}};
                    resp_err_r   <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    gnt_r        <= {NREQ{1'b0}};
                    resp_done_r  <= {NREQ{1'b0}};
                    resp_prodt_r <= {(2*W){1'b0}};
                    resp_err_r   <= 1'b0;
                    mul_start_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign resp_done  = resp_done_r;
    assign resp_prodt = resp_prodt_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;
    assign mul_start  = mul_start_r;
    assign mul_mcand  = mcand_r;
    assign mul_mlier  = mlier_r;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed testbench for mul_share_arb. A single process drives every input
// on the falling edge. It also hosts a behavioural multiplier with
// programmable latency, and logs grant and response events by cycle number.
// Expected values are hand-computed constants.

module tb_mul_share_arb;

    localparam int TO = 64;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_mcand;
    logic [31:0] req_mlier;
    logic [3:0]  gnt;
    logic [3:0]  resp_done;
    logic [15:0] resp_prodt;
    logic        resp_err;
    logic        busy;
    logic        mul_start;
    logic [7:0]  mul_mcand;
    logic [7:0]  mul_mlier;
    logic        mul_done;
    logic [15:0] mul_prodt;

    typedef struct {
        int          cyc;
        logic [3:0]  vec;
        logic [15:0] prodt;
        logic        err;
    } ev_t;

    ev_t         gnt_q[$];
    ev_t         resp_q[$];
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          t0;
    logic [3:0]  hold;
    logic        mdl_on;
    int          mdl_lat;
    int          mdl_rem;
    logic [15:0] mdl_a;
    logic [15:0] mdl_b;
    logic        stray;

    mul_share_arb #(.NREQ(4), .W(8), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_mcand  (req_mcand),
        .req_mlier  (req_mlier),
        .gnt        (gnt),
        .resp_done  (resp_done),
        .resp_prodt (resp_prodt),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_mcand  (mul_mcand),
        .mul_mlier  (mul_mlier),
        .mul_done   (mul_done),
        .mul_prodt  (mul_prodt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter: inside cycle n (after the n-th rising edge) cyc == n
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_mcand[i*8 +: 8] = a;
        req_mlier[i*8 +: 8] = b;
    endtask

    // One cycle: sample outputs at the falling edge, log events, drop granted
    // requests, then advance the multiplier model.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (gnt != 4'd0) begin
            e.cyc = cyc; e.vec = gnt; e.prodt = 16'd0; e.err = 1'b0;
            gnt_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                if (gnt[i] && !hold[i]) req[i] = 1'b0;
            end
        end
        if (resp_done != 4'd0) begin
            e.cyc = cyc; e.vec = resp_done; e.prodt = resp_prodt; e.err = resp_err;
            resp_q.push_back(e);
        end
        mul_done  = 1'b0;
        mul_prodt = 16'hA5A5;
        if (mdl_rem > 0) begin
            mdl_rem--;
            if (mdl_rem == 0 && mdl_on) begin
                mul_done  = 1'b1;
                mul_prodt = mdl_a * mdl_b;
            end
        end
        if (mul_start) begin
            mdl_rem = mdl_lat;
            mdl_a   = {8'd0, mul_mcand};
            mdl_b   = {8'd0, mul_mlier};
        end
        if (stray) begin
            mul_done  = 1'b1;
            mul_prodt = 16'h1234;
            stray     = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_gnts(input int n, input int bound);
        for (int k = 0; k < bound && gnt_q.size() < n; k++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'd0; hold = 4'd0; mdl_rem = 0;
        run(2);
        rst_n = 1'b1;
        tick();
        gnt_q.delete(); resp_q.delete();
    endtask

    // Directed test sequence
    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        rst_n = 1'b0; req = 4'd0; req_mcand = 32'd0; req_mlier = 32'd0;
        mul_done = 1'b0; mul_prodt = 16'hA5A5; hold = 4'd0;
        mdl_on = 1'b1; mdl_lat = 5; mdl_rem = 0; stray = 1'b0;
        mdl_a = 16'd0; mdl_b = 16'd0;
        run(2);
        check_eq("rst_ctrl", 32'({gnt, resp_done, resp_err, busy, mul_start}), 32'd0);
        check_eq("rst_prodt", 32'(resp_prodt), 32'd0);
        check_eq("rst_ops", 32'({mul_mcand, mul_mlier}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single requester, held for two back-to-back transactions
        set_ops(0, 8'hDE, 8'hB7);
        t0 = cyc; req[0] = 1'b1; hold[0] = 1'b1;
        wait_gnts(2, 30);
        req[0] = 1'b0; hold[0] = 1'b0;
        run(12);
        check_eq("t1_ngnt", 32'(gnt_q.size()), 32'd2);
        check_eq("t1_nresp", 32'(resp_q.size()), 32'd2);
        if (gnt_q.size() == 2 && resp_q.size() == 2) begin
            check_eq("t1_gnt_vec", 32'(gnt_q[0].vec), 32'd1);
            check_eq("t1_gnt_cyc", 32'(gnt_q[0].cyc - t0), 32'd1);
            check_eq("t1_resp_cyc", 32'(resp_q[0].cyc - t0), 32'd7);
            check_eq("t1_resp_vec", 32'(resp_q[0].vec), 32'd1);
            check_eq("t1_prodt", 32'(resp_q[0].prodt), 32'h9EB2);
            check_eq("t1_err", 32'(resp_q[0].err), 32'd0);
            check_eq("t1_gnt2_cyc", 32'(gnt_q[1].cyc - t0), 32'd9);
            check_eq("t1_resp2_cyc", 32'(resp_q[1].cyc - t0), 32'd15);
        end
        check_eq("t1_idle", 32'(busy), 32'd0);

        // All four at once, from a fresh pointer
        do_reset();
        set_ops(0, 8'h1E, 8'hB7); set_ops(1, 8'hDB, 8'h95);
        set_ops(2, 8'hFC, 8'hEF); set_ops(3, 8'hFF, 8'hFF);
        req = 4'hF;
        run(45);
        check_eq("t2_ngnt", 32'(gnt_q.size()), 32'd4);
        check_eq("t2_nresp", 32'(resp_q.size()), 32'd4);
        if (gnt_q.size() == 4 && resp_q.size() == 4) begin
            logic [15:0] exp_p [4];
            exp_p[0] = 16'h1572; exp_p[1] = 16'h7F77; exp_p[2] = 16'hEB44; exp_p[3] = 16'hFE01;
            for (int k = 0; k < 4; k++) begin
                check_eq("t2_gnt_vec", 32'(gnt_q[k].vec), 32'd1 << k);
                check_eq("t2_resp_vec", 32'(resp_q[k].vec), 32'd1 << k);
                check_eq("t2_prodt", 32'(resp_q[k].prodt), 32'(exp_p[k]));
                check_eq("t2_err", 32'(resp_q[k].err), 32'd0);
            end
        end

        // Fairness: requester 2 held, requester 1 joins after the first grant
        gnt_q.delete(); resp_q.delete();
        req[2] = 1'b1; hold[2] = 1'b1;
        wait_gnts(1, 10);
        req[1] = 1'b1; hold[1] = 1'b1;
        wait_gnts(4, 60);
        req = 4'd0; hold = 4'd0;
        run(10);
        check_eq("t3_ngnt", 32'(gnt_q.size()), 32'd4);
        if (gnt_q.size() == 4) begin
            check_eq("t3_g0", 32'(gnt_q[0].vec), 32'h4);
            check_eq("t3_g1", 32'(gnt_q[1].vec), 32'h2);
            check_eq("t3_g2", 32'(gnt_q[2].vec), 32'h4);
            check_eq("t3_g3", 32'(gnt_q[3].vec), 32'h2);
        end
        check_eq("t3_nresp", 32'(resp_q.size()), 32'd4);

        // Timeout, then a normal transaction from requester 3
        gnt_q.delete(); resp_q.delete();
        mdl_on = 1'b0;
        set_ops(0, 8'h12, 8'h34);
        req[0] = 1'b1;
        run(75);
        mdl_on = 1'b1;
        set_ops(3, 8'hFF, 8'h02);
        req[3] = 1'b1;
        run(12);
        check_eq("t4_nresp", 32'(resp_q.size()), 32'd2);
        if (gnt_q.size() == 2 && resp_q.size() == 2) begin
            check_eq("t4_to_cyc", 32'(resp_q[0].cyc - gnt_q[0].cyc), 32'(TO + 1));
            check_eq("t4_to_vec", 32'(resp_q[0].vec), 32'h1);
            check_eq("t4_to_err", 32'(resp_q[0].err), 32'd1);
            check_eq("t4_to_prodt", 32'(resp_q[0].prodt), 32'd0);
            check_eq("t4_ok_vec", 32'(resp_q[1].vec), 32'h8);
            check_eq("t4_ok_err", 32'(resp_q[1].err), 32'd0);
            check_eq("t4_ok_prodt", 32'(resp_q[1].prodt), 32'h01FE);
        end

        // Completion on the final watchdog cycle
        gnt_q.delete(); resp_q.delete();
        mdl_lat = TO;
        set_ops(1, 8'h0A, 8'h0B);
        req[1] = 1'b1;
        run(TO + 10);
        check_eq("t5_nresp", 32'(resp_q.size()), 32'd1);
        if (gnt_q.size() == 1 && resp_q.size() == 1) begin
            check_eq("t5_cyc", 32'(resp_q[0].cyc - gnt_q[0].cyc), 32'(TO + 1));
            check_eq("t5_err", 32'(resp_q[0].err), 32'd0);
            check_eq("t5_prodt", 32'(resp_q[0].prodt), 32'h006E);
        end

        // Reset during WAIT, then a stray mul_done while idle
        gnt_q.delete(); resp_q.delete();
        mdl_lat = 10;
        set_ops(0, 8'h03, 8'h05);
        req[0] = 1'b1;
        wait_gnts(1, 10);
        run(3);
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ctrl", 32'({gnt, resp_done, resp_err, busy, mul_start}), 32'd0);
        check_eq("t6_rst_ops", 32'({mul_mcand, mul_mlier}), 32'd0);
        check_eq("t6_rst_prodt", 32'(resp_prodt), 32'd0);
        run(2);
        mdl_rem = 0;
        rst_n = 1'b1;
        tick();
        stray = 1'b1;
        run(3);
        check_eq("t6_stray_busy", 32'(busy), 32'd0);
        check_eq("t6_no_resp", 32'(resp_q.size()), 32'd0);
        gnt_q.delete();
        mdl_lat = 5;
        set_ops(1, 8'h07, 8'h09);
        req[0] = 1'b1; req[1] = 1'b1;
        wait_gnts(2, 30);
        run(10);
        check_eq("t6_ngnt", 32'(gnt_q.size()), 32'd2);
        check_eq("t6_nresp", 32'(resp_q.size()), 32'd2);
        if (gnt_q.size() == 2 && resp_q.size() == 2) begin
            check_eq("t6_g0", 32'(gnt_q[0].vec), 32'h1);
            check_eq("t6_g1", 32'(gnt_q[1].vec), 32'h2);
            check_eq("t6_p0", 32'(resp_q[0].prodt), 32'h000F);
            check_eq("t6_p1", 32'(resp_q[1].prodt), 32'h003F);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
